// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with wait states, lane stores and extended loads
//
// Accepts one load/store request at a time over a valid/ready handshake, inserts
// WAIT_CYCLES wait states, then presents a registered response until it is taken.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   req_valid / req_ready    request handshake (ready only in IDLE, low during reset)
//   req_addr, req_we         byte address, 1 = store
//   req_wdata                LSB-aligned store data
//   req_store_type           00 byte, 01 half, 10 word, 11 reserved
//   req_load_type            000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, others reserved
//   rsp_valid / rsp_ready    response handshake
//   rsp_rdata                extended load data, 0 for stores and errors
//   rsp_err                  misaligned, out-of-range or reserved-type request
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_store_type,
  input  logic [2:0]  req_load_type,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic [31:0] lat_addr, lat_wdata;
  logic        lat_we;
  logic [1:0]  lat_st;
  logic [2:0]  lat_lt;

  logic [31:0] mem [DEPTH_WORDS];

  logic        fire, enter_resp, commit;
  logic [31:0] e_addr, e_wdata;
  logic        e_we;
  logic [1:0]  e_st, e_sz;
  logic [2:0]  e_lt;
  logic        mis, oor, rsvd, err_c;
  logic [AW-1:0] idx;
  logic [31:0] rd_word, rd_shift, ext, load_data, lane_data;
  logic [15:0] half_sel;
  logic [3:0]  lane_en;

  assign fire = req_valid & req_ready;

  // With zero wait states the response is formed on the accept edge itself, so
  // the request fields are taken straight from the inputs while in IDLE.
  always_comb begin
    if (state == S_IDLE) begin
      e_addr  = req_addr;
      e_wdata = req_wdata;
      e_we    = req_we;
      e_st    = req_store_type;
      e_lt    = req_load_type;
    end else begin
      e_addr  = lat_addr;
      e_wdata = lat_wdata;
      e_we    = lat_we;
      e_st    = lat_st;
      e_lt    = lat_lt;
    end
  end

  assign enter_resp = ((state == S_IDLE) && fire && (WAIT_CYCLES == 0)) ||
                      ((state == S_WAIT) && (cnt == 4'd0));

  // Access size code: 00 byte, 01 half, 10 word (11 only for reserved types).
  assign e_sz  = e_we ? e_st : e_lt[1:0];
  assign rsvd  = e_we ? (e_st == 2'b11) : ((e_lt == 3'b011) || (e_lt[2:1] == 2'b11));
  assign mis   = ((e_sz == 2'b01) && e_addr[0]) || ((e_sz == 2'b10) && (e_addr[1:0] != 2'b00));
  assign oor   = {2'b00, e_addr[31:2]} >= 32'(DEPTH_WORDS);
  assign err_c = mis | oor | rsvd;

  assign idx      = e_addr[AW+1:2];
  assign rd_word  = mem[idx];
  assign rd_shift = rd_word >> {e_addr[1:0], 3'b000};
  assign half_sel = e_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ext = 32'd0;
    case (e_lt)
      3'b000:  ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ext = {{16{half_sel[15]}}, half_sel};
      3'b010:  ext = rd_word;
      3'b100:  ext = {24'd0, rd_shift[7:0]};
      3'b101:  ext = {16'd0, half_sel};
      default: ext = 32'd0;
    endcase
  end

  assign load_data = (e_we || err_c) ? 32'd0 : ext;

  always_comb begin
    lane_en   = 4'b0000;
    lane_data = e_wdata;
    case (e_st)
      2'b00: begin
        lane_en   = 4'b0001 << e_addr[1:0];
        lane_data = {4{e_wdata[7:0]}};
      end
      2'b01: begin
        lane_en   = e_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{e_wdata[15:0]}};
      end
      2'b10:   lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  end

  assign commit = enter_resp && e_we && !err_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (fire) next_state = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == 4'd0) next_state = S_RESP;
      S_RESP: if (rsp_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Handshake outputs; ready is held low while reset is asserted
  always_comb begin
    req_ready = (state == S_IDLE) && !rst;
    rsp_valid = (state == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 4'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_we    <= 1'b0;
      lat_st    <= 2'b00;
      lat_lt    <= 3'b000;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (fire) begin
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_we    <= req_we;
        lat_st    <= req_store_type;
        lat_lt    <= req_load_type;
        cnt       <= (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
      end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        rsp_rdata <= load_data;
        rsp_err   <= err_c;
      end
    end
  end

  // Memory array has no reset; only lanes selected by the store type are written.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[idx][8*b +: 8] <= lane_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int          sel;
  logic        rst_all, rst_mid;
  logic        d_valid, d_we, rsp_ready_s;
  logic [31:0] d_addr, d_wdata;
  logic [1:0]  d_st;
  logic [2:0]  d_lt;

  logic        ready0, ready1, ready2, valid0, valid1, valid2, err0, err1, err2;
  logic [31:0] rdata0, rdata1, rdata2;
  logic        c_ready, c_valid, c_err;
  logic [31:0] c_rdata;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst_all), .req_valid(d_valid && sel == 0), .req_ready(ready0),
    .req_addr(d_addr), .req_we(d_we), .req_wdata(d_wdata), .req_store_type(d_st),
    .req_load_type(d_lt), .rsp_valid(valid0), .rsp_ready(rsp_ready_s),
    .rsp_rdata(rdata0), .rsp_err(err0));

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst_all || rst_mid), .req_valid(d_valid && sel == 1), .req_ready(ready1),
    .req_addr(d_addr), .req_we(d_we), .req_wdata(d_wdata), .req_store_type(d_st),
    .req_load_type(d_lt), .rsp_valid(valid1), .rsp_ready(rsp_ready_s),
    .rsp_rdata(rdata1), .rsp_err(err1));

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst_all), .req_valid(d_valid && sel == 2), .req_ready(ready2),
    .req_addr(d_addr), .req_we(d_we), .req_wdata(d_wdata), .req_store_type(d_st),
    .req_load_type(d_lt), .rsp_valid(valid2), .rsp_ready(rsp_ready_s),
    .rsp_rdata(rdata2), .rsp_err(err2));

  always_comb begin
    case (sel)
      1: begin c_ready = ready1; c_valid = valid1; c_err = err1; c_rdata = rdata1; end
      2: begin c_ready = ready2; c_valid = valid2; c_err = err2; c_rdata = rdata2; end
      default: begin c_ready = ready0; c_valid = valid0; c_err = err0; c_rdata = rdata0; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request with rsp_ready held high; returns response, latency in
  // negedges from accept until rsp_valid is seen, and the accept cycle.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] st, input logic [2:0] lt,
                      output logic [31:0] rdata, output logic err, output int lat, output int acc);
    int n;
    @(negedge clk);
    d_we = we; d_addr = addr; d_wdata = wdata; d_st = st; d_lt = lt;
    d_valid = 1'b1; rsp_ready_s = 1'b1;
    n = 0;
    while (!c_ready && n < 50) begin @(negedge clk); n++; end
    check("accept_wait", {31'd0, c_ready}, 32'd1);
    @(posedge clk); #1;
    d_valid = 1'b0;
    acc = cyc;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!c_valid && lat < 50);
    check("rsp_wait", {31'd0, c_valid}, 32'd1);
    rdata = c_rdata;
    err = c_err;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [31:0] rd, hold_rd;
    logic        er, hold_er;
    int          lat, acc, acc_prev, n;

    sel = 0; rst_all = 1'b1; rst_mid = 1'b0;
    d_valid = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_st = '0; d_lt = '0;
    rsp_ready_s = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, c_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, c_valid}, 32'd0);
    check("rst_rsp_rdata", c_rdata, 32'd0);
    check("rst_rsp_err",   {31'd0, c_err}, 32'd0);
    rst_all = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, c_ready}, 32'd1);

    // WAIT_CYCLES=1: word store then load
    xact(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 3'b000, rd, er, lat, acc);
    check("sw_lat", lat, 32'd2);
    check("sw_err", {31'd0, er}, 32'd0);
    check("sw_rdata", rd, 32'd0);
    xact(1'b0, 32'h10, 32'h0, 2'b00, 3'b010, rd, er, lat, acc);
    check("lw_lat", lat, 32'd2);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", {31'd0, er}, 32'd0);

    // Lane stores and loads
    xact(1'b1, 32'h11, 32'h00000080, 2'b00, 3'b000, rd, er, lat, acc);
    check("sb_err", {31'd0, er}, 32'd0);
    xact(1'b0, 32'h10, 32'h0, 2'b00, 3'b010, rd, er, lat, acc);
    check("lw_after_sb", rd, 32'hDEAD80EF);
    xact(1'b0, 32'h11, 32'h0, 2'b00, 3'b000, rd, er, lat, acc);
    check("lb_sign", rd, 32'hFFFFFF80);
    xact(1'b0, 32'h11, 32'h0, 2'b00, 3'b100, rd, er, lat, acc);
    check("lbu_zero", rd, 32'h00000080);
    xact(1'b1, 32'h12, 32'h00001234, 2'b01, 3'b000, rd, er, lat, acc);
    check("sh_err", {31'd0, er}, 32'd0);
    xact(1'b0, 32'h10, 32'h0, 2'b00, 3'b010, rd, er, lat, acc);
    check("lw_after_sh", rd, 32'h123480EF);
    xact(1'b0, 32'h12, 32'h0, 2'b00, 3'b001, rd, er, lat, acc);
    check("lh_pos", rd, 32'h00001234);

    // Errors
    xact(1'b0, 32'h13, 32'h0, 2'b00, 3'b010, rd, er, lat, acc);
    check("lw_mis_err", {31'd0, er}, 32'd1);
    check("lw_mis_rdata", rd, 32'd0);
    xact(1'b1, 32'h14, 32'h55667788, 2'b10, 3'b000, rd, er, lat, acc);
    xact(1'b1, 32'h15, 32'h0000FFFF, 2'b01, 3'b000, rd, er, lat, acc);
    check("sh_mis_err", {31'd0, er}, 32'd1);
    xact(1'b0, 32'h14, 32'h0, 2'b00, 3'b010, rd, er, lat, acc);
    check("word_unchanged", rd, 32'h55667788);
    xact(1'b0, 32'h1000, 32'h0, 2'b00, 3'b010, rd, er, lat, acc);
    check("oor_err", {31'd0, er}, 32'd1);
    xact(1'b0, 32'hFFC, 32'h0, 2'b00, 3'b010, rd, er, lat, acc);
    check("last_word_ok", {31'd0, er}, 32'd0);
    xact(1'b0, 32'h10, 32'h0, 2'b00, 3'b011, rd, er, lat, acc);
    check("rsvd_lt_err", {31'd0, er}, 32'd1);
    check("rsvd_lt_rdata", rd, 32'd0);
    xact(1'b1, 32'h10, 32'hFFFFFFFF, 2'b11, 3'b000, rd, er, lat, acc);
    check("rsvd_st_err", {31'd0, er}, 32'd1);
    xact(1'b0, 32'h10, 32'h0, 2'b00, 3'b010, rd, er, lat, acc);
    check("rsvd_st_no_write", rd, 32'h123480EF);

    // Backpressure
    @(negedge clk);
    d_we = 1'b0; d_addr = 32'h10; d_lt = 3'b010; d_valid = 1'b1; rsp_ready_s = 1'b0;
    @(posedge clk); #1;
    d_valid = 1'b0;
    d_addr = 32'h14;
    n = 0;
    do begin @(negedge clk); n++; end while (!c_valid && n < 50);
    check("bp_rsp_seen", {31'd0, c_valid}, 32'd1);
    hold_rd = c_rdata;
    hold_er = c_err;
    check("bp_rdata", hold_rd, 32'h123480EF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", {31'd0, c_valid}, 32'd1);
      check("bp_rdata_held", c_rdata, 32'h123480EF);
      check("bp_err_held", {31'd0, c_err}, 32'd0);
      check("bp_ready_low", {31'd0, c_ready}, 32'd0);
    end
    rsp_ready_s = 1'b1;
    @(negedge clk);
    check("bp_valid_drop", {31'd0, c_valid}, 32'd0);
    check("bp_ready_back", {31'd0, c_ready}, 32'd1);

    // WAIT_CYCLES=3: reset while a store is waiting
    sel = 1;
    xact(1'b1, 32'h20, 32'h11111111, 2'b10, 3'b000, rd, er, lat, acc);
    check("w3_lat", lat, 32'd4);
    @(negedge clk);
    d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hAAAAAAAA; d_st = 2'b10; d_valid = 1'b1;
    @(posedge clk); #1;
    d_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_mid = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, c_ready}, 32'd0);
    check("mid_rst_valid", {31'd0, c_valid}, 32'd0);
    check("mid_rst_rdata", c_rdata, 32'd0);
    check("mid_rst_err", {31'd0, c_err}, 32'd0);
    @(negedge clk);
    rst_mid = 1'b0;
    #1;
    check("mid_rst_ready_back", {31'd0, c_ready}, 32'd1);
    xact(1'b0, 32'h20, 32'h0, 2'b00, 3'b010, rd, er, lat, acc);
    check("aborted_store", rd, 32'h11111111);

    // WAIT_CYCLES=0: back-to-back requests
    sel = 2;
    xact(1'b1, 32'h40, 32'hCAFEF00D, 2'b10, 3'b000, rd, er, lat, acc);
    check("w0_sw_lat", lat, 32'd1);
    acc_prev = acc;
    xact(1'b0, 32'h40, 32'h0, 2'b00, 3'b010, rd, er, lat, acc);
    check("w0_lw_lat", lat, 32'd1);
    check("w0_lw_rdata", rd, 32'hCAFEF00D);
    check("w0_spacing1", acc - acc_prev, 32'd2);
    acc_prev = acc;
    xact(1'b0, 32'h43, 32'h0, 2'b00, 3'b100, rd, er, lat, acc);
    check("w0_lbu", rd, 32'h000000CA);
    check("w0_spacing2", acc - acc_prev, 32'd2);
    xact(1'b0, 32'h42, 32'h0, 2'b00, 3'b001, rd, er, lat, acc);
    check("w0_lh_neg", rd, 32'hFFFFCAFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
